// File: rtl/fpu_ctrl_div_sqrt_seq.sv
// fpu_ctrl_div_sqrt_seq
// Control sequencer for the iterative divide / square-root unit.
// Accepts one request at a time. Pulses the operand load, then enables the
// mantissa iteration datapath for N steps, strobes the normaliser capture,
// and flags completion. N comes from the precision control sampled at accept.
// The operation can be aborted with a kill.
module fpu_ctrl_div_sqrt_seq #(
    parameter int C_DIV_PC        = 5,
    parameter int C_DIV_FULL_ITER = 25
) (
    input  logic                Clk_CI,
    input  logic                Rst_RBI,
    input  logic                Div_start_SI,
    input  logic                Sqrt_start_SI,
    input  logic                Kill_SI,
    input  logic [C_DIV_PC-1:0] Precision_ctl_SI,
    input  logic                Special_case_SI,
    output logic                Ready_SO,
    output logic                Load_SO,
    output logic                Iter_en_SO,
    output logic [C_DIV_PC-1:0] Iter_cnt_DO,
    output logic                Div_enable_SO,
    output logic                Sqrt_enable_SO,
    output logic                Norm_capture_SO,
    output logic                Done_SO
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_NORM = 2'd3;

    localparam logic [C_DIV_PC-1:0] FULL_ITER = C_DIV_PC'(C_DIV_FULL_ITER);
    localparam logic [C_DIV_PC-1:0] ONE       = C_DIV_PC'(1);

    logic [1:0]          state;
    logic [C_DIV_PC-1:0] iter_cnt;
    logic [C_DIV_PC-1:0] n_latched;
    logic [C_DIV_PC-1:0] n_next;
    logic                div_en;
    logic                sqrt_en;
    logic                done;
    logic                start_req;

    assign start_req = Div_start_SI | Sqrt_start_SI;

    // Iteration count for a request: zero or out-of-range selects full precision.
    always_comb begin
        n_next = FULL_ITER;
        if ((Precision_ctl_SI != '0) && (Precision_ctl_SI < FULL_ITER)) begin
            n_next = Precision_ctl_SI + ONE;
        end
    end

    // Sequencer state, iteration counter, latched mode/iteration count and done flag.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state     <= S_IDLE;
            iter_cnt  <= '0;
            n_latched <= '0;
            div_en    <= 1'b0;
            sqrt_en   <= 1'b0;
            done      <= 1'b0;
        end else if (Kill_SI) begin
            state    <= S_IDLE;
            iter_cnt <= '0;
            div_en   <= 1'b0;
            sqrt_en  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_req) begin
                        state     <= S_LOAD;
                        div_en    <= Div_start_SI;
                        sqrt_en   <= ~Div_start_SI;
                        n_latched <= n_next;
                        iter_cnt  <= '0;
                    end
                end
                S_LOAD: begin
                    iter_cnt <= '0;
                    state    <= Special_case_SI ? S_NORM : S_ITER;
                end
                S_ITER: begin
                    if (iter_cnt == (n_latched - ONE)) begin
                        iter_cnt <= '0;
                        state    <= S_NORM;
                    end else begin
                        iter_cnt <= iter_cnt + ONE;
                    end
                end
                S_NORM: begin
                    state   <= S_IDLE;
                    done    <= 1'b1;
                    div_en  <= 1'b0;
                    sqrt_en <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Every output is a plain decode of registered state or flags.
    assign Ready_SO        = (state == S_IDLE);
    assign Load_SO         = (state == S_LOAD);
    assign Iter_en_SO      = (state == S_ITER);
    assign Norm_capture_SO = (state == S_NORM);
    assign Iter_cnt_DO     = iter_cnt;
    assign Div_enable_SO   = div_en;
    assign Sqrt_enable_SO  = sqrt_en;
    assign Done_SO         = done;

endmodule

// File: tb/tb_fpu_ctrl_div_sqrt_seq.sv
// tb_fpu_ctrl_div_sqrt_seq
// Randomised bench for the div/sqrt sequencer. The driver issues operations
// and pushes the expected outcome of each into a queue; a monitor on the
// falling edge follows each operation from its load pulse and compares.
module tb_fpu_ctrl_div_sqrt_seq;

    localparam int PC   = 5;
    localparam int FULL = 25;

    logic          clk;
    logic          rst_n;
    logic          div_start;
    logic          sqrt_start;
    logic          kill;
    logic [PC-1:0] prec_ctl;
    logic          special;
    logic          ready;
    logic          load;
    logic          iter_en;
    logic [PC-1:0] iter_cnt;
    logic          div_en;
    logic          sqrt_en;
    logic          norm_cap;
    logic          done;

    int total;
    int bad;

    typedef struct {
        bit killed;
        bit is_div;
        int n_iter;
        int lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   active;
    int   mon_lat;
    int   mon_iters;

    fpu_ctrl_div_sqrt_seq #(
        .C_DIV_PC        (PC),
        .C_DIV_FULL_ITER (FULL)
    ) dut (
        .Clk_CI           (clk),
        .Rst_RBI          (rst_n),
        .Div_start_SI     (div_start),
        .Sqrt_start_SI    (sqrt_start),
        .Kill_SI          (kill),
        .Precision_ctl_SI (prec_ctl),
        .Special_case_SI  (special),
        .Ready_SO         (ready),
        .Load_SO          (load),
        .Iter_en_SO       (iter_en),
        .Iter_cnt_DO      (iter_cnt),
        .Div_enable_SO    (div_en),
        .Sqrt_enable_SO   (sqrt_en),
        .Norm_capture_SO  (norm_cap),
        .Done_SO          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Iteration count implied by a precision-control value.
    function automatic int model_n(input int pc);
        if (pc == 0 || pc >= FULL) return FULL;
        return pc + 1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"}, ready, 1);
        checkOutput({tag, "_load"}, load, 0);
        checkOutput({tag, "_iter_en"}, iter_en, 0);
        checkOutput({tag, "_iter_cnt"}, iter_cnt, 0);
        checkOutput({tag, "_div_en"}, div_en, 0);
        checkOutput({tag, "_sqrt_en"}, sqrt_en, 0);
        checkOutput({tag, "_norm_cap"}, norm_cap, 0);
        checkOutput({tag, "_done"}, done, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitReady();
        int guard;
        guard = 0;
        while (!ready && guard < 200) begin
            tick();
            guard++;
        end
        if (!ready) checkOutput("ready_timeout", ready, 1);
    endtask

    // Issue one operation in the current cycle (t0). kill_at selects the cycle
    // (counted from t0) in which kill is raised; values outside the operation
    // mean no kill. Random starts and precision changes are thrown at the DUT
    // while it is busy and must have no effect.
    task automatic applyStimulus(input bit d, input bit s, input int pc,
                                 input bit sp, input int kill_at);
        exp_t e;
        int   n;
        int   t_end;
        int   t_last;
        waitReady();
        n        = model_n(pc);
        t_end    = sp ? 2 : n + 2;
        e.killed = (kill_at >= 1 && kill_at <= t_end);
        e.is_div = d;
        e.n_iter = sp ? 0 : n;
        e.lat    = sp ? 2 : n + 2;
        t_last   = e.killed ? kill_at : t_end;
        exp_q.push_back(e);
        div_start  = d;
        sqrt_start = s;
        prec_ctl   = PC'(pc);
        special    = sp;
        kill       = 1'b0;
        tick();
        for (int c = 1; c <= t_last; c++) begin
            div_start  = 1'($urandom_range(0, 1));
            sqrt_start = 1'($urandom_range(0, 1));
            prec_ctl   = PC'($urandom);
            kill       = (c == kill_at);
            tick();
        end
        div_start  = 1'b0;
        sqrt_start = 1'b0;
        kill       = 1'b0;
        special    = 1'b0;
    endtask

    // Monitor: follows each operation from its load pulse to its end.
    always @(negedge clk) begin
        if (!rst_n) begin
            active = 1'b0;
            exp_q.delete();
        end else begin
            if (active) begin
                mon_lat++;
                if (iter_en) begin
                    checkOutput("iter_cnt_seq", iter_cnt, mon_iters);
                    mon_iters++;
                end
                if (norm_cap) begin
                    checkOutput("norm_div_en", div_en, cur.is_div);
                    checkOutput("norm_sqrt_en", sqrt_en, !cur.is_div);
                end
                if (ready) begin
                    if (done) begin
                        checkOutput("completed_not_killed", 0, cur.killed);
                        checkOutput("iter_count", mon_iters, cur.n_iter);
                        checkOutput("latency", mon_lat, cur.lat);
                    end else begin
                        checkOutput("aborted_was_killed", 1, cur.killed);
                        checkOutput("abort_iter_cnt", iter_cnt, 0);
                    end
                    checkOutput("end_div_en", div_en, 0);
                    checkOutput("end_sqrt_en", sqrt_en, 0);
                    active = 1'b0;
                end
            end else begin
                checkOutput("spurious_done", done, 0);
            end
            if (load) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_load", 1, 0);
                end else begin
                    cur       = exp_q.pop_front();
                    active    = 1'b1;
                    mon_lat   = 0;
                    mon_iters = 0;
                    checkOutput("load_iter_cnt", iter_cnt, 0);
                    checkOutput("load_div_en", div_en, cur.is_div);
                    checkOutput("load_sqrt_en", sqrt_en, !cur.is_div);
                end
            end
        end
    end

    // Directed cases first, then a randomised run, then the final summary.
    initial begin
        int op;
        int pc;
        bit sp;
        int k;
        total      = 0;
        bad        = 0;
        active     = 1'b0;
        rst_n      = 1'b0;
        div_start  = 1'b0;
        sqrt_start = 1'b0;
        kill       = 1'b0;
        prec_ctl   = '0;
        special    = 1'b0;
        #2;
        checkResetValues("reset");
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] directed operations");
        applyStimulus(1, 0, 0, 0, -1);
        applyStimulus(0, 1, 7, 0, -1);
        applyStimulus(1, 0, 3, 1, -1);
        applyStimulus(1, 1, 2, 0, -1);
        applyStimulus(1, 0, 31, 0, -1);
        applyStimulus(0, 1, 24, 0, -1);
        applyStimulus(1, 0, 0, 0, 12);
        applyStimulus(0, 1, 3, 0, 6);
        applyStimulus(1, 0, 5, 1, 2);
        applyStimulus(0, 1, 5, 0, 1);

        $display("[TB] kill together with start in idle");
        waitReady();
        tick();
        div_start = 1'b1;
        kill      = 1'b1;
        tick();
        div_start = 1'b0;
        kill      = 1'b0;
        checkOutput("kill_start_ready", ready, 1);
        checkOutput("kill_start_load", load, 0);
        tick();

        $display("[TB] reset in the middle of iterations");
        waitReady();
        exp_q.push_back('{killed: 1'b1, is_div: 1'b1, n_iter: FULL, lat: FULL + 2});
        div_start = 1'b1;
        prec_ctl  = '0;
        tick();
        div_start = 1'b0;
        repeat (5) tick();
        checkOutput("pre_reset_iter_en", iter_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("mid_reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] randomised operations");
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 2);
            pc = $urandom_range(0, 31);
            sp = ($urandom_range(0, 3) == 0);
            k  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, sp ? 2 : model_n(pc) + 2) : -1;
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) tick();
            applyStimulus(op != 1, op != 0, pc, sp, k);
        end

        repeat (5) tick();
        checkOutput("queue_drained", exp_q.size(), 0);
        checkOutput("monitor_idle", active, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
